// File: rtl/inst_encoder_loader_pkg.sv
// Shared encoder definitions: command enumeration, MIPS opcode/funct
// constants and field-packing helpers used by the instruction loader.
package inst_encoder_loader_pkg;

    typedef enum logic [3:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_AND  = 4'd2,
        CMD_OR   = 4'd3,
        CMD_XOR  = 4'd4,
        CMD_SLT  = 4'd5,
        CMD_SLTU = 4'd6,
        CMD_ADDI = 4'd7,
        CMD_ANDI = 4'd8,
        CMD_ORI  = 4'd9,
        CMD_XORI = 4'd10,
        CMD_SLTI = 4'd11,
        CMD_J    = 4'd12
    } cmd_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    function automatic logic [31:0] enc_r(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] funct
    );
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/inst_encoder_loader_pack.sv
// Combinational command-to-word encoder; flags commands outside the
// defined enumeration as illegal.
module inst_pack
    import inst_encoder_loader_pkg::*;
(
    input  logic [3:0]  cmd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        unique case (cmd)
            CMD_ADD:  word = enc_r(rs, rt, rd, FN_ADD);
            CMD_SUB:  word = enc_r(rs, rt, rd, FN_SUB);
            CMD_AND:  word = enc_r(rs, rt, rd, FN_AND);
            CMD_OR:   word = enc_r(rs, rt, rd, FN_OR);
            CMD_XOR:  word = enc_r(rs, rt, rd, FN_XOR);
            CMD_SLT:  word = enc_r(rs, rt, rd, FN_SLT);
            CMD_SLTU: word = enc_r(rs, rt, rd, FN_SLTU);
            CMD_ADDI: word = enc_i(OP_ADDI, rs, rt, imm);
            CMD_ANDI: word = enc_i(OP_ANDI, rs, rt, imm);
            CMD_ORI:  word = enc_i(OP_ORI, rs, rt, imm);
            CMD_XORI: word = enc_i(OP_XORI, rs, rt, imm);
            CMD_SLTI: word = enc_i(OP_SLTI, rs, rt, imm);
            CMD_J:    word = {OP_J, target};
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Session-based loader: accepts symbolic commands and writes encoded
// MIPS words sequentially into instruction memory from address 0.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          req_valid_i,
    output logic          req_ready,
    input  logic [3:0]    cmd_i,
    input  logic [4:0]    rs_i,
    input  logic [4:0]    rt_i,
    input  logic [4:0]    rd_i,
    input  logic [15:0]   imm_i,
    input  logic [25:0]   target_i,
    input  logic          last_i,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err_illegal,
    output logic          err_full
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [31:0]   word;
    logic          legal;
    logic [AW+1:0] occ;
    logic          at_cap;
    logic          accept;

    inst_pack u_pack (
        .cmd    (cmd_i),
        .rs     (rs_i),
        .rt     (rt_i),
        .rd     (rd_i),
        .imm    (imm_i),
        .target (target_i),
        .word   (word),
        .legal  (legal)
    );

    // A registered write not yet reflected in count still occupies a slot.
    assign occ       = {1'b0, count} + {{(AW+1){1'b0}}, imem_we};
    assign at_cap    = occ >= (AW+2)'(DEPTH);
    assign req_ready = (state == S_LOAD) && !at_cap;
    assign accept    = req_valid_i && req_ready;
    assign done      = (state == S_DONE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= 32'h0;
            count       <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) count <= count + 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state       <= S_LOAD;
                        count       <= '0;
                        err_illegal <= 1'b0;
                        err_full    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (req_valid_i && at_cap) err_full <= 1'b1;
                    if (accept) begin
                        if (legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= occ[AW-1:0];
                            imem_wdata <= word;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                        if (last_i) state <= S_DRAIN;
                    end
                end
                S_DRAIN: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed self-checking bench for inst_encoder_loader (DEPTH=4 so the
// capacity limit is reachable with a handful of commands).
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  cmd;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
    logic        imem_we;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;
    logic        done;
    logic        err_illegal;
    logic        err_full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.DEPTH(4), .AW(2)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .req_valid_i (req_valid),
        .req_ready   (req_ready),
        .cmd_i       (cmd),
        .rs_i        (rs),
        .rt_i        (rt),
        .rd_i        (rd),
        .imm_i       (imm),
        .target_i    (target),
        .last_i      (last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .count       (count),
        .done        (done),
        .err_illegal (err_illegal),
        .err_full    (err_full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d,
                         input logic [15:0] i, input logic [25:0] tg,
                         input logic l);
        cmd = c; rs = s; rt = t; rd = d; imm = i; target = tg; last = l;
        req_valid = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; req_valid = 1'b0;
        cmd = 4'd0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0; last = 1'b0;
        #3;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0b want 0", req_ready); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b want 0", imem_we); end
        n_checks++; if (imem_addr !== 2'd0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0b want 0", done); end
        n_checks++; if ({err_illegal, err_full} !== 2'b00) begin n_fail++; $display("FAIL rst_err got %b want 00", {err_illegal, err_full}); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_start();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %0b want 1", req_ready); end
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL single_we got %0b want 1", imem_we); end
        n_checks++; if (imem_addr !== 2'd0) begin n_fail++; $display("FAIL single_addr got %0d want 0", imem_addr); end
        n_checks++; if (imem_wdata !== 32'h00221820) begin n_fail++; $display("FAIL single_wdata got %h want 00221820", imem_wdata); end
        tick();
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %0b want 0", imem_we); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done got %0b want 1", done); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
    endtask

    task automatic test_back_to_back();
        do_start();
        drive(4'd7, 5'd0, 5'd5, 5'h1F, 16'hFFFF, 26'h0, 1'b0);
        tick();
        n_checks++; if ({imem_we, imem_addr} !== 3'b100) begin n_fail++; $display("FAIL b2b_w0 got we=%0b addr=%0d want we=1 addr=0", imem_we, imem_addr); end
        n_checks++; if (imem_wdata !== 32'h2005FFFF) begin n_fail++; $display("FAIL b2b_d0 got %h want 2005ffff", imem_wdata); end
        drive(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1);
        tick();
        req_valid = 1'b0;
        n_checks++; if ({imem_we, imem_addr} !== 3'b101) begin n_fail++; $display("FAIL b2b_w1 got we=%0b addr=%0d want we=1 addr=1", imem_we, imem_addr); end
        n_checks++; if (imem_wdata !== 32'h08000010) begin n_fail++; $display("FAIL b2b_d1 got %h want 08000010", imem_wdata); end
        tick();
        n_checks++; if ({done, count} !== 4'b1010) begin n_fail++; $display("FAIL b2b_end got done=%0b count=%0d want 1/2", done, count); end
    endtask

    task automatic test_illegal();
        do_start();
        drive(4'd1, 5'd4, 5'd5, 5'd6, 16'h1234, 26'h0, 1'b0);
        tick();
        n_checks++; if ({imem_we, imem_addr} !== 3'b100) begin n_fail++; $display("FAIL ill_w0 got we=%0b addr=%0d want 1/0", imem_we, imem_addr); end
        n_checks++; if (imem_wdata !== 32'h00853022) begin n_fail++; $display("FAIL ill_d0 got %h want 00853022", imem_wdata); end
        drive(4'd14, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        tick();
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL ill_nowrite got %0b want 0", imem_we); end
        n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %0b want 1", err_illegal); end
        drive(4'd1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        n_checks++; if ({imem_we, imem_addr} !== 3'b101) begin n_fail++; $display("FAIL ill_w1 got we=%0b addr=%0d want 1/1", imem_we, imem_addr); end
        n_checks++; if (imem_wdata !== 32'h00E84822) begin n_fail++; $display("FAIL ill_d1 got %h want 00e84822", imem_wdata); end
        tick();
        n_checks++; if ({done, count, err_illegal} !== 5'b10101) begin n_fail++; $display("FAIL ill_end got done=%0b count=%0d ill=%0b want 1/2/1", done, count, err_illegal); end
    endtask

    task automatic test_full();
        int nw = 0;
        do_start();
        drive(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (imem_we === 1'b1) begin
                n_checks++; if (imem_addr !== nw[1:0]) begin n_fail++; $display("FAIL full_addr got %0d want %0d", imem_addr, nw); end
                nw++;
            end
        end
        n_checks++; if (nw != 4) begin n_fail++; $display("FAIL full_writes got %0d want 4", nw); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", req_ready); end
        n_checks++; if (err_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %0b want 1", err_full); end
        n_checks++; if ({count, done} !== 4'b1000) begin n_fail++; $display("FAIL full_count got count=%0d done=%0b want 4/0", count, done); end
        req_valid = 1'b0;
    endtask

    task automatic test_abort();
        int stray = 0;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        do_start();
        drive(4'd2, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0, 1'b0);
        tick(); tick();
        n_checks++; if ({imem_we, imem_addr} !== 3'b101) begin n_fail++; $display("FAIL abort_pre got we=%0b addr=%0d want 1/1", imem_we, imem_addr); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({imem_we, imem_addr, req_ready} !== 4'b0000) begin n_fail++; $display("FAIL abort_ctl got we=%0b addr=%0d rdy=%0b want 0", imem_we, imem_addr, req_ready); end
        n_checks++; if ({imem_wdata, count} !== 35'h0) begin n_fail++; $display("FAIL abort_data got wdata=%h count=%0d want 0", imem_wdata, count); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (imem_we !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abort_stray got %0d want 0", stray); end
        req_valid = 1'b0;
    endtask

    task automatic test_restart();
        do_start();
        drive(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if ({done, err_illegal, count} !== 5'b11000) begin n_fail++; $display("FAIL rs_pre got done=%0b ill=%0b count=%0d want 1/1/0", done, err_illegal, count); end
        do_start();
        n_checks++; if ({done, err_illegal, err_full, req_ready} !== 4'b0001) begin n_fail++; $display("FAIL rs_clear got %b want 0001", {done, err_illegal, err_full, req_ready}); end
        drive(4'd4, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b1);
        tick();
        req_valid = 1'b0;
        n_checks++; if ({imem_we, imem_addr} !== 3'b100) begin n_fail++; $display("FAIL rs_w got we=%0b addr=%0d want 1/0", imem_we, imem_addr); end
        n_checks++; if (imem_wdata !== 32'h00432026) begin n_fail++; $display("FAIL rs_d got %h want 00432026", imem_wdata); end
        tick();
        n_checks++; if ({done, count} !== 4'b1001) begin n_fail++; $display("FAIL rs_end got done=%0b count=%0d want 1/1", done, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_full();
        test_abort();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
